// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding and memory geometry.
package mips_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam int WORD_BYTES = 4;
  localparam int IMEM_DEPTH = 64;
endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction memory port, control inputs, decode-side outputs.
// master = fetch_controller, slave = core/memory environment.
interface fetch_controller_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [15:0] fetch_count;
  logic        fault;
  logic [1:0]  state;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, fetch_count, fault, state,
    input  imem_instr, stall, redirect_valid, redirect_target, halt_req
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, fetch_count, fault, state,
    output imem_instr, stall, redirect_valid, redirect_target, halt_req
  );
endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC mux. Priority: halt (freeze) > redirect > stall (hold) > pc+4.
// Redirect targets are forced word-aligned.
module fetch_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        stall,
  input  logic        advance,
  output logic [31:0] pc_next
);

  // Priority select; pc+4 wraps naturally at 2^32.
  always_comb begin
    pc_next = pc;
    if (halt)          pc_next = pc;
    else if (redirect) pc_next = {target[31:2], 2'b00};
    else if (stall)    pc_next = pc;
    else if (advance)  pc_next = pc + 32'(WORD_BYTES);
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues one word per cycle toward
// decode, handles stall/redirect/halt. Optional macro IMEM_BOUND_CHECK_EN
// turns out-of-range RUN fetches into a sticky fault plus halt.
module fetch_controller
  import mips_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  fetch_controller_if.master bus
);

  if (DEPTH <= 0) begin : g_bad_depth
    $error("fetch_controller: DEPTH must be positive");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_controller: RESET_PC must be word-aligned");
  end

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, ipc_q;
  logic         vld_q;
  logic [15:0]  cnt_q;
  logic         issue, clr_valid, oob, live, redir, frozen;

  assign live   = (state_q == RUN) || (state_q == HOLD);
  assign redir  = bus.redirect_valid && live;
  // PC only moves in RUN/HOLD; BOOT and HALT keep it where it is.
  assign frozen = bus.halt_req || !live;

`ifdef IMEM_BOUND_CHECK_EN
  localparam logic [31:0] LIMIT = 32'(DEPTH * WORD_BYTES);
  logic fault_set;
  logic fault_q;
  assign oob       = (pc_q >= LIMIT);
  assign fault_set = (state_q == RUN) && !bus.halt_req && !bus.redirect_valid
                     && !bus.stall && oob;
  assign bus.fault = fault_q;
`else
  assign oob       = 1'b0;
  assign bus.fault = 1'b0;
`endif

  // Next-state and issue decision; halt beats redirect beats stall.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    clr_valid = 1'b0;
    case (state_q)
      BOOT: begin
        if (bus.halt_req) begin state_d = HALT; clr_valid = 1'b1; end
        else              state_d = RUN;
      end
      RUN, HOLD: begin
        if (bus.halt_req) begin
          state_d = HALT; clr_valid = 1'b1;
        end else if (bus.redirect_valid) begin
          state_d = RUN; clr_valid = 1'b1;
        end else if (state_q == HOLD) begin
          // Release cycle back to RUN issues nothing.
          if (!bus.stall) state_d = RUN;
        end else if (bus.stall) begin
          state_d = HOLD;
        end else if (oob) begin
          state_d = HALT; clr_valid = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  fetch_pc_sel u_pc_sel (
    .pc      (pc_q),
    .halt    (frozen),
    .redirect(redir),
    .target  (bus.redirect_target),
    .stall   (bus.stall),
    .advance (issue),
    .pc_next (pc_d)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Decode-side output registers and saturating issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (issue) begin
        instr_q <= bus.imem_instr;
        ipc_q   <= pc_q;
        vld_q   <= 1'b1;
      end else if (clr_valid) begin
        vld_q   <= 1'b0;
      end
      if (issue && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef IMEM_BOUND_CHECK_EN
  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = vld_q;
  assign bus.fetch_count = cnt_q;
  assign bus.state       = state_q;

endmodule
